// File: rtl/result_drain_pkg.sv
// Shared types and default sizing for the result_drain block.
package result_drain_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int unsigned N_DEFAULT     = 32;
    localparam int unsigned BURST_DEFAULT = 64;
    localparam int unsigned DEPTH_DEFAULT = 64;

    // Number of free entries, given the occupancy of a DEPTH-entry FIFO.
    function automatic int unsigned free_slots(input int unsigned depth, input int unsigned used);
        return depth - used;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO; head word reads as zero while empty.
module result_fifo #(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO only takes a push when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= AW'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/result_drain.sv
// Drains 64-word MAC result blocks into a FIFO and re-streams them over valid/ready.
// Optional burst summation is enabled by defining RESULT_DRAIN_SUM_EN.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned BURST = BURST_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              RDY_blockRead,
    output logic                              EN_blockRead,
    input  logic                              VALID_memVal,
    input  logic [N-1:0]                      memVal_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N-1:0]                      out_data,
    output logic                              out_last,
    output logic                              busy,
`ifdef RESULT_DRAIN_SUM_EN
    output logic                              sum_valid,
    output logic [N+$clog2(BURST)-1:0]        sum_data,
`endif
    output logic                              err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(BURST);

    state_t        state;
    state_t        state_nx;
    logic [BW-1:0] beat;
    logic [BW-1:0] beat_nx;
    logic [CW-1:0] count;
    logic [N:0]    head;
    logic          push;
    logic          pop;
    logic          last_beat;
    logic          drop;
    logic          space_ok;
    logic          full;

    result_fifo #(
        .W     (N + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (push),
        .push_data ({last_beat, memVal_data}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_last  = head[N];
    assign out_data  = head[N-1:0];
    assign pop       = out_valid && out_ready;
    assign full      = (count == CW'(DEPTH));
    assign space_ok  = (CW'(free_slots(DEPTH, 32'(count))) >= CW'(BURST));

    // Next state, block-read request, push and drop decisions.
    always_comb begin
        state_nx     = state;
        beat_nx      = beat;
        EN_blockRead = 1'b0;
        push         = 1'b0;
        last_beat    = 1'b0;
        drop         = 1'b0;
        case (state)
            IDLE: begin
                EN_blockRead = RDY_blockRead && space_ok;
                drop         = VALID_memVal;
                if (EN_blockRead) begin
                    state_nx = COLLECT;
                    beat_nx  = '0;
                end
            end
            COLLECT: begin
                if (VALID_memVal) begin
                    push      = 1'b1;
                    last_beat = (beat == BW'(BURST - 1));
                    beat_nx   = BW'(beat + 1'b1);
                    drop      = full && !pop;
                    if (last_beat) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            beat  <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            busy  <= (state_nx == COLLECT);
            err   <= err || drop;
        end
    end

`ifdef RESULT_DRAIN_SUM_EN
    localparam int unsigned SW = N + BW;

    logic [SW-1:0] acc;
    logic [SW-1:0] acc_nx;

    assign acc_nx = SW'(acc + SW'(memVal_data));

    // Accumulator restarts with each block request; result published after the last beat.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc       <= '0;
            sum_valid <= 1'b0;
            sum_data  <= '0;
        end else begin
            sum_valid <= push && last_beat;
            if (EN_blockRead) begin
                acc <= '0;
            end else if (push) begin
                acc <= acc_nx;
            end
            if (push && last_beat) begin
                sum_data <= acc_nx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain against a queue-based behavioural model.
module tb_result_drain;

    localparam int unsigned N     = 32;
    localparam int unsigned BURST = 64;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned BW    = 6;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          RDY_blockRead = 1'b0;
    logic          EN_blockRead;
    logic          VALID_memVal = 1'b0;
    logic [N-1:0]  memVal_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          err;
`ifdef RESULT_DRAIN_SUM_EN
    logic          sum_valid;
    logic [N+BW-1:0] sum_data;
`endif

    result_drain #(.N(N), .BURST(BURST), .DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .RDY_blockRead (RDY_blockRead),
        .EN_blockRead  (EN_blockRead),
        .VALID_memVal  (VALID_memVal),
        .memVal_data   (memVal_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
`ifdef RESULT_DRAIN_SUM_EN
        .sum_valid     (sum_valid),
        .sum_data      (sum_data),
`endif
        .err           (err)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: words waiting downstream, burst progress, sticky error, burst sum.
    logic [N:0]      q[$];
    bit              m_busy;
    bit              m_err;
    bit              m_en;
    bit              en_seen;
    int              m_beat;
    longint unsigned m_acc;
    longint unsigned m_sum_data;
    bit              m_sum_valid;
    int unsigned     errors = 0;
    int unsigned     checks = 0;

    task automatic model_clear();
        q.delete();
        m_busy      = 0;
        m_err       = 0;
        m_beat      = 0;
        m_acc       = 0;
        m_sum_valid = 0;
        m_sum_data  = 0;
    endtask

    // One clock: drive inputs, note EN, apply the edge to the model, land on the next negedge.
    task automatic cycle(input bit rdy, input bit vld, input logic [N-1:0] d, input bit rdyo);
        bit   pop;
        bit   full;
        logic last;
        RDY_blockRead = rdy;
        VALID_memVal  = vld;
        memVal_data   = d;
        out_ready     = rdyo;
        #1;
        m_en    = rdy && !m_busy && ((DEPTH - q.size()) >= BURST);
        en_seen = EN_blockRead;
        @(posedge CLK);
        pop  = (q.size() != 0) && rdyo;
        full = (q.size() == DEPTH);
        m_sum_valid = 0;
        if (pop) void'(q.pop_front());
        if (vld && m_busy && !(full && !pop)) begin
            last = (m_beat == BURST - 1);
            q.push_back({last, d});
            m_acc += longint'(d);
            m_beat++;
            if (m_beat == BURST) begin
                m_busy      = 0;
                m_sum_valid = 1;
                m_sum_data  = m_acc;
            end
        end else if (vld) begin
            m_err = 1;
        end
        if (m_en) begin
            m_busy = 1;
            m_beat = 0;
            m_acc  = 0;
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        RDY_blockRead = 1'b0;
        VALID_memVal  = 1'b0;
        out_ready     = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        model_clear();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (EN_blockRead !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", EN_blockRead); end
`ifdef RESULT_DRAIN_SUM_EN
        checks++; if ({sum_valid, sum_data} !== '0) begin errors++; $display("FAIL reset_sum: got %b/%h want 0/0", sum_valid, sum_data); end
`endif
    endtask

    // Sequential words 0..BURST-1 with the consumer always ready.
    task automatic test_basic();
        bit started = 0;
        int sent = 0;
        int pulses = 0;
        for (int c = 0; c < BURST + 10; c++) begin
            bit vld;
            vld = m_busy && (sent < BURST);
            cycle(!started, vld, N'(sent), 1'b1);
            if (vld) sent++;
            if (m_en) begin started = 1; pulses++; end
            checks++; if (en_seen !== m_en) begin errors++; $display("FAIL basic_en: got %b want %b cyc %0d", en_seen, m_en, c); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL basic_valid: got %b want %b cyc %0d", out_valid, q.size() != 0, c); end
            if (q.size() != 0) begin
                checks++; if ({out_last, out_data} !== q[0]) begin errors++; $display("FAIL basic_head: got %b/%h want %b/%h", out_last, out_data, q[0][N], q[0][N-1:0]); end
            end
            checks++; if ({busy, err} !== {m_busy, m_err}) begin errors++; $display("FAIL basic_flags: got busy=%b err=%b want %b %b", busy, err, m_busy, m_err); end
        end
        checks++; if (sent != BURST || pulses != 1) begin errors++; $display("FAIL basic_count: got sent=%0d pulses=%0d want %0d 1", sent, pulses, BURST); end
    endtask

    // Full FIFO blocks the next request until every word has been popped.
    task automatic test_backpressure();
        int phase = 0;
        int sent = 0;
        int hold = 0;
        int starts = 0;
        for (int c = 0; c < 4 * BURST + 40 && phase < 4; c++) begin
            bit rdy;
            bit rdyo;
            bit vld;
            rdy  = (phase == 0) || (phase == 1) || (phase == 2);
            rdyo = (phase >= 2);
            vld  = m_busy && (sent < BURST);
            cycle(rdy, vld, N'($urandom), rdyo);
            if (vld) sent++;
            if (m_en) begin starts++; sent = 0; end
            checks++; if (en_seen !== m_en) begin errors++; $display("FAIL bp_en: got %b want %b phase %0d", en_seen, m_en, phase); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL bp_valid: got %b want %b", out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if ({out_last, out_data} !== q[0]) begin errors++; $display("FAIL bp_head: got %b/%h want %b/%h", out_last, out_data, q[0][N], q[0][N-1:0]); end
            end
            checks++; if ({busy, err} !== {m_busy, m_err}) begin errors++; $display("FAIL bp_flags: got %b%b want %b%b", busy, err, m_busy, m_err); end
            case (phase)
                0: if (starts == 1) phase = 1;
                1: if (!m_busy && sent == BURST) begin
                       checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %b want 1", out_valid); end
                       hold++;
                       if (hold == 6) phase = 2;
                   end
                2: if (starts == 2) phase = 3;
                default: if (!m_busy && q.size() == 0) phase = 4;
            endcase
        end
        checks++; if (phase != 4 || starts != 2) begin errors++; $display("FAIL bp_timeout: got phase=%0d starts=%0d want 4 2", phase, starts); end
    endtask

    // Beats arrive every other cycle with a random consumer.
    task automatic test_gaps();
        bit started = 0;
        int sent = 0;
        int c;
        for (c = 0; c < 6 * BURST; c++) begin
            bit vld;
            vld = m_busy && (sent < BURST) && (c % 2 == 1);
            cycle(!started, vld, N'($urandom), 1'($urandom));
            if (vld) sent++;
            if (m_en) started = 1;
            checks++; if (en_seen !== m_en) begin errors++; $display("FAIL gap_en: got %b want %b", en_seen, m_en); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL gap_valid: got %b want %b", out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if ({out_last, out_data} !== q[0]) begin errors++; $display("FAIL gap_head: got %b/%h want %b/%h", out_last, out_data, q[0][N], q[0][N-1:0]); end
            end
            checks++; if ({busy, err} !== {m_busy, m_err}) begin errors++; $display("FAIL gap_flags: got %b%b want %b%b", busy, err, m_busy, m_err); end
            if (started && !m_busy && q.size() == 0) break;
        end
        checks++; if (sent != BURST || err !== 1'b0) begin errors++; $display("FAIL gap_done: got sent=%0d err=%b want %0d 0", sent, err, BURST); end
    endtask

    // Beats outside a burst are dropped and latch err.
    task automatic test_idle_drop();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, c < 3, N'($urandom), 1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", out_valid); end
            checks++; if ({busy, err} !== {m_busy, m_err}) begin errors++; $display("FAIL drop_flags: got %b%b want %b%b", busy, err, m_busy, m_err); end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", err); end
    endtask

    // Reset at beat 30 clears everything; a fresh burst then streams normally.
    task automatic test_mid_reset();
        bit started = 0;
        int sent = 0;
        for (int c = 0; c < BURST && sent < 30; c++) begin
            bit vld;
            vld = m_busy;
            cycle(!started, vld, N'($urandom), 1'b0);
            if (vld) sent++;
            if (m_en) started = 1;
        end
        RST_N = 1'b0;
        RDY_blockRead = 1'b0;
        VALID_memVal  = 1'b0;
        out_ready     = 1'b1;
        @(posedge CLK);
        model_clear();
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
        checks++; if (EN_blockRead !== 1'b0) begin errors++; $display("FAIL mrst_en: got %b want 0", EN_blockRead); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mrst_err: got %b want 0", err); end
        RST_N = 1'b1;
        started = 0;
        sent = 0;
        for (int c = 0; c < 4 * BURST; c++) begin
            bit vld;
            vld = m_busy && ($urandom_range(3) != 0);
            cycle(!started, vld, N'($urandom), 1'($urandom));
            if (vld) sent++;
            if (m_en) started = 1;
            checks++; if (en_seen !== m_en) begin errors++; $display("FAIL fresh_en: got %b want %b", en_seen, m_en); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL fresh_valid: got %b want %b", out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if ({out_last, out_data} !== q[0]) begin errors++; $display("FAIL fresh_head: got %b/%h want %b/%h", out_last, out_data, q[0][N], q[0][N-1:0]); end
            end
            checks++; if ({busy, err} !== {m_busy, m_err}) begin errors++; $display("FAIL fresh_flags: got %b%b want %b%b", busy, err, m_busy, m_err); end
            if (started && !m_busy && q.size() == 0) break;
        end
        checks++; if (sent != BURST) begin errors++; $display("FAIL fresh_done: got sent=%0d want %0d", sent, BURST); end
    endtask

    // All-ones burst: one sum pulse with 64 * (2^32-1).
    task automatic test_sum();
`ifdef RESULT_DRAIN_SUM_EN
        bit started = 0;
        int pulses = 0;
        logic [N+BW-1:0] want_const;
        want_const = 38'h3F_FFFF_FFC0;
        for (int c = 0; c < BURST + 8; c++) begin
            bit vld;
            vld = m_busy;
            cycle(!started, vld, 32'hFFFF_FFFF, 1'b1);
            if (m_en) started = 1;
            checks++; if (sum_valid !== m_sum_valid) begin errors++; $display("FAIL sum_valid: got %b want %b", sum_valid, m_sum_valid); end
            if (sum_valid === 1'b1) begin
                pulses++;
                checks++; if (sum_data !== (N+BW)'(m_sum_data)) begin errors++; $display("FAIL sum_model: got %h want %h", sum_data, (N+BW)'(m_sum_data)); end
                checks++; if (sum_data !== want_const) begin errors++; $display("FAIL sum_const: got %h want %h", sum_data, want_const); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL sum_pulses: got %0d want 1", pulses); end
        checks++; if (sum_data !== want_const) begin errors++; $display("FAIL sum_hold: got %h want %h", sum_data, want_const); end
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_idle_drop();
        test_mid_reset();
        test_sum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_drain.md
# result_drain

Read-side consumer of the MAC result memory. When the MAC reports a full 64-entry result block (RDY_blockRead), result_drain reserves buffer space, requests the block with a one-cycle EN_blockRead pulse, and captures every VALID_memVal beat into an internal FIFO. It then re-streams the words downstream over a valid/ready interface with a per-burst last flag. This decouples the MAC's fixed, non-stallable 64-cycle read burst from a back-pressured consumer.

## Interface
- N, 32, data word width; matches MAC result width.
- BURST, 64, words per block read; matches the MAC 6-bit address space.
- DEPTH, 64, FIFO entries; power of two, DEPTH >= BURST.
- CLK in 1: clock; all logic is posedge.
- RST_N in 1: reset, synchronous, active-low.
- RDY_blockRead in 1: the MAC has a full block ready to read.
- EN_blockRead out 1: one-cycle request to start a block read.
- VALID_memVal in 1: memVal_data carries a valid result this cycle.
- memVal_data in N: result word from the MAC.
- out_valid out 1: out_data/out_last hold a valid word.
- out_ready in 1: the downstream consumer accepts the word.
- out_data out N: head-of-FIFO word.
- out_last out 1: the head word is word BURST-1 of its burst.
- busy out 1: a burst is in progress (state COLLECT).
- err out 1: sticky; set when a beat is dropped; cleared only by reset.

## Operation
- FSM states: IDLE, COLLECT.
- IDLE:
  - EN_blockRead = RDY_blockRead && (DEPTH - count >= BURST). This is combinational.
  - When EN_blockRead is high, the next state is COLLECT and the beat counter is cleared.
- COLLECT:
  - EN_blockRead = 0.
  - Each cycle with VALID_memVal=1 pushes {beat==BURST-1, memVal_data} and increments the beat counter.
  - On the push with beat==BURST-1, the next state is IDLE.
  - Cycles with VALID_memVal=0 inside a burst are tolerated. The counter holds and the FSM stays in COLLECT indefinitely.
- Space reservation: a burst starts only when BURST free entries exist. Pops during the burst only increase free space, so an in-burst push never meets a full FIFO.
- Dropped beats: VALID_memVal=1 while in IDLE, or a push when count==DEPTH with no same-cycle pop. The beat is discarded and err is set.
- FIFO behaviour:
  - First-word-fall-through.
  - out_valid = (count != 0).
  - A pop occurs when out_valid && out_ready.
  - Simultaneous push and pop: count is unchanged and both pointers advance. When full, a push is accepted only if a pop occurs in the same cycle.
- Pointer and counter widths:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - The beat counter is log2(BURST) bits.
- Reset:
  - All outputs are 0, the FIFO is empty, state is IDLE, and err=0.
  - Reset mid-burst discards buffered and in-flight words. The MAC shares RST_N and is reset in the same cycle.

## Timing
- EN_blockRead is asserted in the same cycle RDY_blockRead is seen with space available. It is high for exactly one cycle because the state leaves IDLE.
- Capture latency: a beat sampled at edge k appears on out_data with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one push and one pop per cycle, sustained.
- busy rises the cycle after the EN_blockRead pulse and falls the cycle after the final beat is captured.
- With out_ready held at 1, the output stream mirrors VALID_memVal delayed by one cycle.

## Configuration
- Macro RESULT_DRAIN_SUM_EN.
- Defined: adds two ports.
  - sum_valid out 1: one-cycle pulse on the cycle after the final beat of a burst is captured.
  - sum_data out N+log2(BURST): unsigned sum of all BURST words of that burst.
  - The accumulator clears on EN_blockRead.
  - sum_valid and sum_data reset to 0; sum_data holds its value between pulses.
- Undefined: the ports and the accumulator are absent; all other behaviour is identical.

## Structure
- Package result_drain_pkg holds:
  - the state_t enum (IDLE, COLLECT);
  - default constants BURST_DEFAULT=64 and DEPTH_DEFAULT=64.
- Sub-module result_fifo: a synchronous FWFT FIFO, width N+1, with push/pop/count ports. It owns the pointer and count logic.
- The top level holds the FSM, the beat counter, err, and the optional accumulator.

## Test plan
- Reset, then RDY_blockRead=1, out_ready=1 -> EN_blockRead pulses one cycle; 64 beats of values 0..63 emerge one cycle late; out_last=1 only with data 63.
- out_ready=0 throughout a burst -> count=64 and out_valid=1. A second RDY_blockRead produces no EN_blockRead until 64 pops occur; then it pulses.
- Burst with VALID_memVal gaps (every other cycle) -> 64 words captured in order, no err, busy held across the gaps.
- VALID_memVal=1 while in IDLE -> word not output; err=1 and stays 1 until RST_N=0.
- RST_N=0 at beat 30 -> next cycle out_valid=0, busy=0, EN_blockRead=0; a fresh burst afterwards works normally.
- With RESULT_DRAIN_SUM_EN, all 64 words = 0xFFFFFFFF -> sum_valid pulses once with sum_data = 0x3F_FFFFFFC0.
